// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit 5-stage pipeline: opcodes, operand-use
// decode helpers, hazard FSM state type and forward-select encodings.
// Imported by pipeline_hazard_ctrl and fwd_unit.
package cpu_pkg;

  localparam logic [4:0] OP_NOP   = 5'h00;
  localparam logic [4:0] OP_ADD   = 5'h01;
  localparam logic [4:0] OP_MUL   = 5'h0C;
  localparam logic [4:0] OP_LOAD  = 5'h10;
  localparam logic [4:0] OP_STORE = 5'h11;
  localparam logic [4:0] OP_BEQ   = 5'h15;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_MULTI = 1'b1
  } hz_state_e;

  // Every opcode except NOP reads rs1 (loads/stores use it as the base).
  function automatic logic uses_rs1(input logic [4:0] op);
    return (op != OP_NOP);
  endfunction

  // Loads only read the base register; NOP reads nothing.
  function automatic logic uses_rs2(input logic [4:0] op);
    return (op != OP_NOP) && (op != OP_LOAD);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_unit.sv
// EX-stage operand forwarding select: purely combinational.
// Ports: ex_rs1_i/ex_rs2_i sources, mem_*/wb_* destination info in,
// fwd_a_o/fwd_b_o selects out (EX/MEM beats MEM/WB, default register file).
module fwd_unit
  import cpu_pkg::*;
(
  input  logic [2:0] ex_rs1_i,
  input  logic [2:0] ex_rs2_i,
  input  logic [2:0] mem_rd_i,
  input  logic       mem_reg_write_i,
  input  logic [2:0] wb_rd_i,
  input  logic       wb_reg_write_i,
  output logic [1:0] fwd_a_o,
  output logic [1:0] fwd_b_o
);

  function automatic logic [1:0] sel(input logic [2:0] rs);
    if (mem_reg_write_i && (mem_rd_i == rs))     return FWD_EXMEM;
    else if (wb_reg_write_i && (wb_rd_i == rs))  return FWD_MEMWB;
    else                                         return FWD_RF;
  endfunction

  assign fwd_a_o = sel(ex_rs1_i);
  assign fwd_b_o = sel(ex_rs2_i);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller: PC/IF-ID/ID-EX enables and flushes for
// load-use, taken branch and multi-cycle MUL, plus forwarding selects and a
// saturating stall counter. Macro HAZARD_FWD_EN enables forwarding; without it
// every RAW dependency on EX/MEM/WB stalls instead. Outputs are combinational.
module pipeline_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int MUL_CYCLES  = 4,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4:0]             id_opcode,
  input  logic                   id_addressing_mode,
  input  logic [2:0]             id_rs1,
  input  logic [2:0]             id_rs2,
  input  logic [4:0]             ex_opcode,
  input  logic [2:0]             ex_rd,
  input  logic [2:0]             ex_rs1,
  input  logic [2:0]             ex_rs2,
  input  logic                   ex_reg_write,
  input  logic                   ex_branch_taken,
  input  logic [2:0]             mem_rd,
  input  logic                   mem_reg_write,
  input  logic [2:0]             wb_rd,
  input  logic                   wb_reg_write,
  output logic                   pc_en,
  output logic                   pc_load,
  output logic                   if_id_en,
  output logic                   id_ex_en,
  output logic                   if_id_flush,
  output logic                   id_ex_flush,
  output logic                   ex_mem_bubble,
  output logic                   mul_busy,
  output logic [1:0]             fwd_a,
  output logic [1:0]             fwd_b,
  output logic [STALL_CNT_W-1:0] stall_count
);

  // Entry cycle is spent in RUN, so MULTI lasts MUL_CYCLES-1 cycles.
  localparam logic [2:0] MCNT_INIT = 3'(MUL_CYCLES - 2);

  hz_state_e              state_q, state_d;
  logic [2:0]             mcnt_q, mcnt_d;
  logic [STALL_CNT_W-1:0] stall_q;

  logic rs1_used, rs2_used;
  logic match_ex, load_use, raw_stall;
  logic [1:0] fwd_a_raw, fwd_b_raw;

  assign rs1_used = uses_rs1(id_opcode);
  assign rs2_used = uses_rs2(id_opcode) && !id_addressing_mode;
  assign match_ex = (rs1_used && (id_rs1 == ex_rd)) || (rs2_used && (id_rs2 == ex_rd));
  assign load_use = (ex_opcode == OP_LOAD) && match_ex;

`ifdef HAZARD_FWD_EN
  assign raw_stall = 1'b0;

  fwd_unit u_fwd (
    .ex_rs1_i        (ex_rs1),
    .ex_rs2_i        (ex_rs2),
    .mem_rd_i        (mem_rd),
    .mem_reg_write_i (mem_reg_write),
    .wb_rd_i         (wb_rd),
    .wb_reg_write_i  (wb_reg_write),
    .fwd_a_o         (fwd_a_raw),
    .fwd_b_o         (fwd_b_raw)
  );
`else
  logic match_mem, match_wb;
  logic unused_ex_srcs;

  assign match_mem = (rs1_used && (id_rs1 == mem_rd)) || (rs2_used && (id_rs2 == mem_rd));
  assign match_wb  = (rs1_used && (id_rs1 == wb_rd))  || (rs2_used && (id_rs2 == wb_rd));
  // Any in-flight producer of a used source blocks ID; this also covers load-use.
  assign raw_stall = (match_ex  && ex_reg_write)  ||
                     (match_mem && mem_reg_write) ||
                     (match_wb  && wb_reg_write);
  assign fwd_a_raw = FWD_RF;
  assign fwd_b_raw = FWD_RF;
  // EX source fields only matter when forwarding exists.
  assign unused_ex_srcs = ^{ex_rs1, ex_rs2};
`endif

  // Output decode: reset > MULTI > branch > MUL entry > load-use/RAW > idle.
  always_comb begin
    pc_en         = 1'b1;
    pc_load       = 1'b0;
    if_id_en      = 1'b1;
    id_ex_en      = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_bubble = 1'b0;
    mul_busy      = 1'b0;
    fwd_a         = fwd_a_raw;
    fwd_b         = fwd_b_raw;
    if (!rst) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_en    = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      fwd_a       = FWD_RF;
      fwd_b       = FWD_RF;
    end else if (state_q == ST_MULTI) begin
      // EX holds the MUL, so a taken-branch flag here is stale and ignored.
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_ex_en      = 1'b0;
      ex_mem_bubble = 1'b1;
      mul_busy      = 1'b1;
    end else if (ex_branch_taken) begin
      pc_load     = 1'b1;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (ex_opcode == OP_MUL) begin
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_ex_en      = 1'b0;
      ex_mem_bubble = 1'b1;
    end else if (load_use || raw_stall) begin
      // ID/EX still captures, but captures a bubble.
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    mcnt_d  = mcnt_q;
    if (state_q == ST_MULTI) begin
      if (mcnt_q == 3'd0) state_d = ST_RUN;
      else                mcnt_d  = mcnt_q - 3'd1;
    end else if (!ex_branch_taken && (ex_opcode == OP_MUL)) begin
      state_d = ST_MULTI;
      mcnt_d  = MCNT_INIT;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
      mcnt_q  <= 3'd0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      mcnt_q  <= mcnt_d;
      if (!pc_en && (stall_q != {STALL_CNT_W{1'b1}}))
        stall_q <= stall_q + 1'b1;
    end
  end

  assign stall_count = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  localparam int SCW = 4;  // narrow counter so saturation is reachable
`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  // {pc_en, pc_load, if_id_en, id_ex_en, if_id_flush, id_ex_flush, ex_mem_bubble, mul_busy}
  localparam logic [7:0] C_RST   = 8'b0000_1100;
  localparam logic [7:0] C_NORM  = 8'b1011_0000;
  localparam logic [7:0] C_STALL = 8'b0001_0100;
  localparam logic [7:0] C_BR    = 8'b1111_1100;
  localparam logic [7:0] C_MULE  = 8'b0000_0010;
  localparam logic [7:0] C_MULB  = 8'b0000_0011;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [4:0] id_opcode, ex_opcode;
  logic id_addressing_mode;
  logic [2:0] id_rs1, id_rs2, ex_rd, ex_rs1, ex_rs2, mem_rd, wb_rd;
  logic ex_reg_write, ex_branch_taken, mem_reg_write, wb_reg_write;
  logic pc_en, pc_load, if_id_en, id_ex_en, if_id_flush, id_ex_flush;
  logic ex_mem_bubble, mul_busy;
  logic [1:0] fwd_a, fwd_b;
  logic [SCW-1:0] stall_count;

  pipeline_hazard_ctrl #(.MUL_CYCLES(4), .STALL_CNT_W(SCW)) dut (
    .clk(clk), .rst(rst),
    .id_opcode(id_opcode), .id_addressing_mode(id_addressing_mode),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_opcode(ex_opcode), .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_reg_write(ex_reg_write), .ex_branch_taken(ex_branch_taken),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .pc_en(pc_en), .pc_load(pc_load), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_bubble(ex_mem_bubble), .mul_busy(mul_busy),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_count(stall_count)
  );

  typedef struct {
    logic [7:0] ctl;
    logic [1:0] fa;
    logic [1:0] fb;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0;
  int n_err = 0;
  int exp_sc = 0;

  task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Inputs are already set (just after a rising edge); queue the expectation,
  // compare on the falling edge, then advance the stall-count model.
  task automatic step(input logic [7:0] ctl, input logic [1:0] fa, input logic [1:0] fb);
    exp_t e, g;
    e.ctl = ctl; e.fa = fa; e.fb = fb;
    sb.push_back(e);
    @(negedge clk);
    g = sb.pop_front();
    if (!rst) exp_sc = 0;
    expect_eq("ctl", {24'b0, pc_en, pc_load, if_id_en, id_ex_en, if_id_flush,
                      id_ex_flush, ex_mem_bubble, mul_busy}, {24'b0, g.ctl});
    expect_eq("fwd_a", {30'b0, fwd_a}, {30'b0, g.fa});
    expect_eq("fwd_b", {30'b0, fwd_b}, {30'b0, g.fb});
    expect_eq("stall_count", {28'b0, stall_count}, 32'(exp_sc));
    if (rst && !g.ctl[7] && exp_sc < (1 << SCW) - 1) exp_sc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_opcode = 5'h01; id_addressing_mode = 1'b0; id_rs1 = 3'd1; id_rs2 = 3'd1;
    ex_opcode = 5'h00; ex_rd = 3'd0; ex_rs1 = 3'd0; ex_rs2 = 3'd0;
    ex_reg_write = 1'b0; ex_branch_taken = 1'b0;
    mem_rd = 3'd0; mem_reg_write = 1'b0; wb_rd = 3'd0; wb_reg_write = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    @(posedge clk); #1;
    step(C_RST, 2'b00, 2'b00);                 // reset values
    rst = 1'b1;
    step(C_NORM, 2'b00, 2'b00);                // idle

    // Load-use on rs1: one stall, then normal.
    ex_opcode = 5'h10; ex_rd = 3'd3; id_rs1 = 3'd3;
    step(C_STALL, 2'b00, 2'b00);
    ex_opcode = 5'h00;
    step(C_NORM, 2'b00, 2'b00);                // stall_count = 1 here

    // Immediate mode: rs2 not a source -> no stall; register mode -> stall.
    ex_opcode = 5'h10; ex_rd = 3'd3; id_rs1 = 3'd5; id_rs2 = 3'd3; id_addressing_mode = 1'b1;
    step(C_NORM, 2'b00, 2'b00);
    id_addressing_mode = 1'b0;
    step(C_STALL, 2'b00, 2'b00);

    // MUL, 4 cycles: entry + 3 in MULTI; a branch flag in MULTI is ignored.
    idle_inputs();
    ex_opcode = 5'h0C;
    step(C_MULE, 2'b00, 2'b00);
    step(C_MULB, 2'b00, 2'b00);
    ex_branch_taken = 1'b1;
    step(C_MULB, 2'b00, 2'b00);
    ex_branch_taken = 1'b0;
    step(C_MULB, 2'b00, 2'b00);
    ex_opcode = 5'h00;
    step(C_NORM, 2'b00, 2'b00);

    // Branch wins over a coincident load-use.
    ex_opcode = 5'h10; ex_rd = 3'd3; id_rs1 = 3'd3; ex_branch_taken = 1'b1;
    step(C_BR, 2'b00, 2'b00);
    idle_inputs();
    step(C_NORM, 2'b00, 2'b00);

    // Forwarding priority / RAW stall without forwarding.
    ex_rs1 = 3'd2; mem_rd = 3'd2; wb_rd = 3'd2; mem_reg_write = 1'b1; wb_reg_write = 1'b1;
    id_rs1 = 3'd2; id_rs2 = 3'd6;
    step(FWD ? C_NORM : C_STALL, FWD ? 2'b01 : 2'b00, 2'b00);
    mem_reg_write = 1'b0; ex_rs2 = 3'd2;
    step(FWD ? C_NORM : C_STALL, FWD ? 2'b10 : 2'b00, FWD ? 2'b10 : 2'b00);
    wb_reg_write = 1'b0;
    step(C_NORM, 2'b00, 2'b00);
    ex_opcode = 5'h01; ex_rd = 3'd2; ex_reg_write = 1'b1;
    step(FWD ? C_NORM : C_STALL, 2'b00, 2'b00);
    idle_inputs();

    // Held load-use drives the counter into saturation.
    ex_opcode = 5'h10; ex_rd = 3'd3; id_rs1 = 3'd3;
    for (int i = 0; i < 18; i++) step(C_STALL, 2'b00, 2'b00);
    idle_inputs();
    step(C_NORM, 2'b00, 2'b00);                // counter pinned at all-ones

    // Reset during MULTI aborts at once; first cycle after release is RUN.
    ex_opcode = 5'h0C;
    step(C_MULE, 2'b00, 2'b00);
    step(C_MULB, 2'b00, 2'b00);
    rst = 1'b0;
    step(C_RST, 2'b00, 2'b00);
    rst = 1'b1; ex_opcode = 5'h00;
    step(C_NORM, 2'b00, 2'b00);
    step(C_NORM, 2'b00, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central hazard and sequencing controller for the 5-stage pipeline of the 8-bit processor. It generates enable, flush and PC-control signals for the PC, IF/ID and ID/EX pipeline latches, resolving load-use hazards, taken branches and multi-cycle multiply operations. It also drives the EX-stage operand forwarding selects and keeps a saturating stall counter. It sits beside the decode stage and observes the ID, EX, MEM and WB stage fields.

## Interface
Parameters:
- MUL_CYCLES, 4 — total EX occupancy of OP_MUL in cycles; legal range 2..8.
- STALL_CNT_W, 16 — width of the stall counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- id_opcode  in  5  opcode in the ID stage.
- id_addressing_mode  in  1  1 = immediate; rs2 is not a source.
- id_rs1, id_rs2  in  3 each  ID source registers.
- ex_opcode  in  5  opcode in the EX stage.
- ex_rd, ex_rs1, ex_rs2  in  3 each  EX destination and source registers.
- ex_reg_write  in  1  EX instruction writes rd.
- ex_branch_taken  in  1  branch resolved taken in EX.
- mem_rd  in  3  MEM destination register.
- mem_reg_write  in  1  MEM instruction writes rd.
- wb_rd  in  3  WB destination register.
- wb_reg_write  in  1  WB instruction writes rd.
- pc_en  out  1  PC advances.
- pc_load  out  1  PC loads the branch target.
- if_id_en, id_ex_en  out  1 each  latch capture enables.
- if_id_flush, id_ex_flush  out  1 each  latch loads a bubble (NOP, reg_write = 0).
- ex_mem_bubble  out  1  EX/MEM inserts a bubble while the multiply is incomplete.
- mul_busy  out  1  FSM is in MULTI.
- fwd_a, fwd_b  out  2 each  operand select: 00 = register file, 01 = EX/MEM, 10 = MEM/WB.
- stall_count  out  STALL_CNT_W  number of cycles in which pc_en was 0 with reset deasserted; saturates at all-ones.

## Operation
- FSM states: RUN and MULTI. The FSM holds a 3-bit down-counter `mcnt`.
- Source use:
  - rs1 is used when `uses_rs1(id_opcode)` is true.
  - rs2 is used when `uses_rs2(id_opcode)` is true and id_addressing_mode = 0.
- Load-use hazard (RUN only): ex_opcode == OP_LOAD, and ex_rd equals a used ID source. Response for that cycle:
  - pc_en = 0, if_id_en = 0, id_ex_flush = 1.
  - Lasts exactly one cycle, because the bubble advances the load into MEM.
- MUL:
  - Entry: in RUN with ex_opcode == OP_MUL, the FSM enters MULTI and loads mcnt = MUL_CYCLES-2.
  - In MULTI: pc_en = if_id_en = id_ex_en = 0, ex_mem_bubble = 1, mul_busy = 1. mcnt decrements each cycle.
  - Exit: when mcnt == 0, the FSM returns to RUN at the next edge.
  - The entry cycle itself also asserts ex_mem_bubble and holds the upstream stages.
- Branch: ex_branch_taken = 1 in RUN gives, for one cycle:
  - pc_load = 1, pc_en = 1.
  - if_id_flush = 1, id_ex_flush = 1.
- Priority: branch > MUL > load-use > RAW stall. ex_branch_taken is ignored in MULTI, since EX holds the MUL.
- Forwarding, fwd_a from ex_rs1 and fwd_b from ex_rs2:
  - 01 when mem_reg_write and mem_rd matches.
  - Otherwise 10 when wb_reg_write and wb_rd matches.
  - Otherwise 00. EX/MEM takes precedence over MEM/WB.
- Idle/default: all enables = 1, flushes = 0, pc_load = 0.

## Timing
- All outputs are combinational from the registered state (FSM, mcnt, stall_count) and the current inputs. There is no added latency.
- While rst is low:
  - FSM = RUN, mcnt = 0, stall_count = 0.
  - pc_en = if_id_en = id_ex_en = 0; if_id_flush = id_ex_flush = 1.
  - pc_load = 0, ex_mem_bubble = 0, mul_busy = 0, fwd_a = fwd_b = 00.
- Reset asserted mid-MULTI aborts immediately to RUN. The first edge after release is a normal RUN cycle.
- stall_count increments on the edge ending each stall cycle. It holds at 2^STALL_CNT_W-1.
- Back-to-back MUL: the second MUL reaches EX only after exit and re-enters MULTI on its own.

## Configuration
- HAZARD_FWD_EN defined: forwarding as described above.
- HAZARD_FWD_EN undefined:
  - fwd_a = fwd_b = 00 always.
  - An additional RAW stall applies in RUN: a used ID source matches ex_rd&ex_reg_write, mem_rd&mem_reg_write, or wb_rd&wb_reg_write.
  - The RAW stall has the same response as load-use and repeats each cycle until clear.
  - The load-use rule is subsumed by this stall.

## Structure
- Shared package `cpu_pkg`:
  - Opcode constants OP_LOAD = 5'h10, OP_STORE = 5'h11, OP_MUL = 5'h0C, OP_BEQ = 5'h15.
  - Functions `uses_rs1` and `uses_rs2`.
  - FSM state enum.
  - Forward-select constants FWD_RF, FWD_EXMEM, FWD_MEMWB.
- One sub-module, `fwd_unit`: the combinational forwarding selects, instanced only under HAZARD_FWD_EN.

## Test plan
- Load-use: ex_opcode = OP_LOAD, ex_rd = 3, id_rs1 = 3 (add) → one cycle with pc_en = 0, id_ex_flush = 1; the next cycle is normal; stall_count = 1.
- Immediate mode: same as load-use but with id_rs2 = 3, id_rs1 = 5, id_addressing_mode = 1 → no stall.
- MUL with MUL_CYCLES = 4: ex_opcode = OP_MUL → 4 cycles of ex_mem_bubble = 1; mul_busy high for 3 cycles; stall_count = 4.
- Branch coinciding with load-use: ex_branch_taken = 1 → pc_load = 1, both flushes = 1, no stall.
- Forwarding priority (HAZARD_FWD_EN): ex_rs1 = 2, mem_rd = 2, wb_rd = 2, both reg_write = 1 → fwd_a = 01. Without the macro: fwd_a = 00 and the design stalls until the writes clear.
- Reset pulse low during MULTI → outputs take their reset values immediately; after release the FSM is in RUN and stall_count = 0.
